// File: rtl/tcdm_to_axi_pkg.sv
// Shared types and fixed AXI field values for the TCDM-to-AXI4 manager bridge.
// The bridge issues single-beat INCR transactions whose size equals the data width.
package tcdm_to_axi_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdWidth   = 1;
  localparam int unsigned UserWidth = 1;

  // Kind of each in-flight transaction, kept in issue order.
  typedef enum logic {
    ORDER_READ  = 1'b0,
    ORDER_WRITE = 1'b1
  } order_e;

  typedef enum logic [3:0] {
    AMO_NONE = 4'h0,
    AMO_SWAP = 4'h1,
    AMO_ADD  = 4'h2,
    AMO_AND  = 4'h3,
    AMO_OR   = 4'h4,
    AMO_XOR  = 4'h5,
    AMO_MAX  = 4'h6,
    AMO_MIN  = 4'h7
  } amo_e;

  localparam logic [IdWidth-1:0] AxiId        = '0;
  localparam logic [7:0]         AxiLen       = 8'd0;
  localparam logic [2:0]         AxiSize      = 3'($clog2(StrbWidth));
  localparam logic [1:0]         AxiBurstIncr = 2'b01;
  localparam logic [1:0]         AxiRespOkay  = 2'b00;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    amo_e                 amo;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic [UserWidth-1:0] user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    tcdm_rsp_chan_t p;
    logic           p_valid;
  } tcdm_rsp_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
    logic [UserWidth-1:0] user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_rsp_t;

  function automatic axi_aw_chan_t make_aw(input logic [AddrWidth-1:0] addr);
    axi_aw_chan_t aw;
    aw       = '0;
    aw.id    = AxiId;
    aw.addr  = addr;
    aw.len   = AxiLen;
    aw.size  = AxiSize;
    aw.burst = AxiBurstIncr;
    return aw;
  endfunction

  function automatic axi_ar_chan_t make_ar(input logic [AddrWidth-1:0] addr);
    axi_ar_chan_t ar;
    ar       = '0;
    ar.id    = AxiId;
    ar.addr  = addr;
    ar.len   = AxiLen;
    ar.size  = AxiSize;
    ar.burst = AxiBurstIncr;
    return ar;
  endfunction

endpackage

// File: rtl/tcdm_to_axi_order_fifo.sv
// Small FIFO recording READ/WRITE of each in-flight transaction so responses
// are accepted in issue order. Push and pop may happen in the same cycle.
module tcdm_to_axi_order_fifo
  import tcdm_to_axi_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  order_e data_i,
  input  logic   pop_i,
  output order_e data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);

  order_e              mem_q [Depth];
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CntFull);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/tcdm_to_axi.sv
// TCDM initiator port to AXI4 manager bridge: one single-beat AXI transaction per
// TCDM request, up to NumOutstanding in flight, responses returned in request order.
module tcdm_to_axi
  import tcdm_to_axi_pkg::*;
#(
  parameter int unsigned NumOutstanding = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  tcdm_req_t tcdm_req_i,
  output tcdm_rsp_t tcdm_rsp_o,
  output axi_req_t  axi_req_o,
  input  axi_rsp_t  axi_rsp_i,
  output logic      busy_o,
  output logic      err_o
);

  localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(NumOutstanding);

  logic [CntWidth-1:0]  count_q;
  logic                 aw_done_q, w_done_q;
  logic                 p_valid_q, err_q;
  logic [DataWidth-1:0] p_data_q;

  logic   gate, is_write;
  logic   ar_valid, aw_valid, w_valid;
  logic   ar_hs, aw_hs, w_hs;
  logic   rd_accept, wr_accept, push;
  logic   r_ready, b_ready, r_hs, b_hs, pop;
  logic   resp_err;
  order_e head;
  logic   fifo_full, fifo_empty;

  // All channels use strict valid/ready: a transfer happens in the cycle where
  // both are high; the TCDM q side completes when q_valid and q_ready are both high,
  // and the initiator keeps q stable until then.
  assign gate     = tcdm_req_i.q_valid && (count_q != CntMax);
  assign is_write = tcdm_req_i.q.write;

  assign ar_valid = gate && !is_write;
  assign aw_valid = gate && is_write && !aw_done_q;
  assign w_valid  = gate && is_write && !w_done_q;

  assign ar_hs = ar_valid && axi_rsp_i.ar_ready;
  assign aw_hs = aw_valid && axi_rsp_i.aw_ready;
  assign w_hs  = w_valid  && axi_rsp_i.w_ready;

  assign rd_accept = ar_hs;
  assign wr_accept = gate && is_write && (aw_done_q || aw_hs) && (w_done_q || w_hs);
  assign push      = rd_accept || wr_accept;

  assign r_ready = !fifo_empty && (head == ORDER_READ);
  assign b_ready = !fifo_empty && (head == ORDER_WRITE);
  assign r_hs    = r_ready && axi_rsp_i.r_valid;
  assign b_hs    = b_ready && axi_rsp_i.b_valid;
  assign pop     = r_hs || b_hs;

  assign resp_err = (r_hs && (axi_rsp_i.r.resp != AxiRespOkay)) ||
                    (b_hs && (axi_rsp_i.b.resp != AxiRespOkay));

  tcdm_to_axi_order_fifo #(
    .Depth(NumOutstanding)
  ) u_order_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .data_i (is_write ? ORDER_WRITE : ORDER_READ),
    .pop_i  (pop),
    .data_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      p_valid_q <= 1'b0;
      p_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_accept) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
      p_valid_q <= pop;
      p_data_q  <= r_hs ? axi_rsp_i.r.data : '0;
      err_q     <= resp_err;
    end
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw       = make_aw(tcdm_req_i.q.addr);
    axi_req_o.aw_valid = aw_valid;
    axi_req_o.w.data   = tcdm_req_i.q.data;
    axi_req_o.w.strb   = tcdm_req_i.q.strb;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid;
    axi_req_o.b_ready  = b_ready;
    axi_req_o.ar       = make_ar(tcdm_req_i.q.addr);
    axi_req_o.ar_valid = ar_valid;
    axi_req_o.r_ready  = r_ready;
  end

  always_comb begin
    tcdm_rsp_o          = '0;
    tcdm_rsp_o.q_ready  = push;
    tcdm_rsp_o.p.data   = p_data_q;
    tcdm_rsp_o.p_valid  = p_valid_q;
  end

  assign busy_o = (count_q != '0) || aw_done_q || w_done_q || p_valid_q;
  assign err_o  = err_q;

  logic unused_bits;
  assign unused_bits = ^{tcdm_req_i.q.amo, tcdm_req_i.q.user, axi_rsp_i.b.id,
                         axi_rsp_i.b.user, axi_rsp_i.r.id, axi_rsp_i.r.last,
                         axi_rsp_i.r.user, fifo_full};

  // Atomics are executed as plain accesses; flag any attempt in simulation.
  amo_unsupported: assert property (@(posedge clk_i) disable iff (rst_i)
    !(tcdm_req_i.q_valid && (tcdm_req_i.q.amo != AMO_NONE)));

endmodule

// File: tb/tb_tcdm_to_axi.sv
// Bench for tcdm_to_axi: two instances (4 and 2 outstanding), a queue-based
// per-cycle reference model each, and directed scenarios with literal expectations.
module tb_tcdm_to_axi;
  import tcdm_to_axi_pkg::*;

  logic clk;
  logic rst;

  tcdm_req_t req  [2];
  tcdm_rsp_t trsp [2];
  axi_req_t  areq [2];
  axi_rsp_t  arsp [2];
  logic      busy [2];
  logic      err  [2];

  int checks = 0;
  int errors = 0;
  int aw_cnt [2];
  int w_cnt  [2];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not end within the time limit");
    $fatal(1, "timeout");
  end

  function automatic void chk(input string name, input int inst,
                              input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h, required %0h", name, inst, $time, act, exp);
    end
  endfunction

  // ---------------- DUTs and reference models ----------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned N = (g == 0) ? 4 : 2;

    tcdm_to_axi #(
      .NumOutstanding(N)
    ) u_dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .tcdm_req_i(req[g]),
      .tcdm_rsp_o(trsp[g]),
      .axi_req_o (areq[g]),
      .axi_rsp_i (arsp[g]),
      .busy_o    (busy[g]),
      .err_o     (err[g])
    );

    bit                   kind_q[$];  // 1 = write, in issue order
    bit                   aw_seen, w_seen;
    bit                   pv, pe;
    logic [DataWidth-1:0] pd;

    initial begin
      aw_cnt[g] = 0;
      w_cnt[g]  = 0;
      aw_seen = 0; w_seen = 0; pv = 0; pe = 0; pd = '0;
      @(posedge clk);
      forever begin
        automatic bit open, wr, e_ar, e_aw, e_w, aw_hs, w_hs, e_qr, e_rr, e_br, r_hs, b_hs;
        automatic axi_aw_chan_t x_aw;
        automatic axi_ar_chan_t x_ar;
        automatic axi_w_chan_t  x_w;
        @(negedge clk);
        wr    = req[g].q.write;
        open  = req[g].q_valid && (kind_q.size() < N);
        e_ar  = open && !wr;
        e_aw  = open && wr && !aw_seen;
        e_w   = open && wr && !w_seen;
        aw_hs = e_aw && arsp[g].aw_ready;
        w_hs  = e_w && arsp[g].w_ready;
        e_qr  = (e_ar && arsp[g].ar_ready) ||
                (open && wr && (aw_seen || aw_hs) && (w_seen || w_hs));
        e_rr  = (kind_q.size() > 0) && (kind_q[0] == 1'b0);
        e_br  = (kind_q.size() > 0) && (kind_q[0] == 1'b1);

        chk("ar_valid", g, 128'(areq[g].ar_valid), 128'(e_ar));
        chk("aw_valid", g, 128'(areq[g].aw_valid), 128'(e_aw));
        chk("w_valid",  g, 128'(areq[g].w_valid),  128'(e_w));
        chk("q_ready",  g, 128'(trsp[g].q_ready),  128'(e_qr));
        chk("r_ready",  g, 128'(areq[g].r_ready),  128'(e_rr));
        chk("b_ready",  g, 128'(areq[g].b_ready),  128'(e_br));
        chk("p_valid",  g, 128'(trsp[g].p_valid),  128'(pv));
        chk("err",      g, 128'(err[g]),           128'(pe));
        chk("busy",     g, 128'(busy[g]),
            128'((kind_q.size() != 0) || aw_seen || w_seen || pv));
        if (pv) chk("p_data", g, 128'(trsp[g].p.data), 128'(pd));

        x_aw = '0; x_aw.addr = req[g].q.addr; x_aw.size = 3'd2; x_aw.burst = 2'b01;
        x_ar = '0; x_ar.addr = req[g].q.addr; x_ar.size = 3'd2; x_ar.burst = 2'b01;
        x_w  = '0; x_w.data = req[g].q.data; x_w.strb = req[g].q.strb; x_w.last = 1'b1;
        if (e_aw) chk("aw_fields", g, 128'(areq[g].aw), 128'(x_aw));
        if (e_ar) chk("ar_fields", g, 128'(areq[g].ar), 128'(x_ar));
        if (e_w)  chk("w_fields",  g, 128'(areq[g].w),  128'(x_w));

        if (areq[g].aw_valid && arsp[g].aw_ready) aw_cnt[g]++;
        if (areq[g].w_valid && arsp[g].w_ready)   w_cnt[g]++;

        if (rst) begin
          kind_q.delete();
          aw_seen = 0; w_seen = 0; pv = 0; pe = 0; pd = '0;
        end else begin
          r_hs = e_rr && arsp[g].r_valid;
          b_hs = e_br && arsp[g].b_valid;
          pv   = r_hs || b_hs;
          pd   = r_hs ? arsp[g].r.data : '0;
          pe   = (r_hs && arsp[g].r.resp != 2'b00) || (b_hs && arsp[g].b.resp != 2'b00);
          if (pv) void'(kind_q.pop_front());
          if (e_qr && wr) begin
            aw_seen = 0; w_seen = 0;
          end else begin
            if (aw_hs) aw_seen = 1;
            if (w_hs)  w_seen  = 1;
          end
          if (e_qr) kind_q.push_back(wr);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle(input int i);
    req[i]  = '0;
    arsp[i] = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
    req[i].q_valid = v;
    req[i].q.write = wr;
    req[i].q.addr  = addr;
    req[i].q.data  = data;
    req[i].q.strb  = 4'hF;
    req[i].q.amo   = AMO_NONE;
    req[i].q.user  = '0;
  endtask

  task automatic set_ready(input int i, input logic aw, input logic w, input logic ar);
    arsp[i].aw_ready = aw;
    arsp[i].w_ready  = w;
    arsp[i].ar_ready = ar;
  endtask

  task automatic set_r(input int i, input logic v, input logic [31:0] data, input logic [1:0] resp);
    arsp[i].r_valid = v;
    arsp[i].r.data  = data;
    arsp[i].r.resp  = resp;
    arsp[i].r.last  = 1'b1;
  endtask

  task automatic set_b(input int i, input logic v, input logic [1:0] resp);
    arsp[i].b_valid = v;
    arsp[i].b.resp  = resp;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int aw0, w0;
    rst = 1'b1;
    idle(0);
    idle(1);
    cyc(2);
    smp();
    for (int i = 0; i < 2; i++) begin
      chk("rst_q_ready", i, 128'(trsp[i].q_ready), 128'(0));
      chk("rst_p_valid", i, 128'(trsp[i].p_valid), 128'(0));
      chk("rst_p_data",  i, 128'(trsp[i].p.data),  128'(0));
      chk("rst_busy",    i, 128'(busy[i]),         128'(0));
      chk("rst_axi_vr",  i, 128'({areq[i].aw_valid, areq[i].w_valid, areq[i].ar_valid,
                                  areq[i].r_ready, areq[i].b_ready}), 128'(0));
    end
    cyc();
    rst = 1'b0;
    cyc(2);

    // Single read of 0x100, R returned three cycles after acceptance.
    set_req(0, 1, 0, 32'h100, 32'h0); set_ready(0, 0, 0, 1);
    smp(); chk("rd_q_ready_c0", 0, 128'(trsp[0].q_ready), 128'(1));
    cyc(); set_req(0, 0, 0, 32'h0, 32'h0); set_ready(0, 0, 0, 0);
    cyc(2); set_r(0, 1, 32'hDEADBEEF, 2'b00);
    smp(); chk("rd_r_ready", 0, 128'(areq[0].r_ready), 128'(1));
    cyc(); set_r(0, 0, 32'h0, 2'b00);
    smp();
    chk("rd_p_valid", 0, 128'(trsp[0].p_valid), 128'(1));
    chk("rd_p_data",  0, 128'(trsp[0].p.data),  128'(32'hDEADBEEF));
    chk("rd_err",     0, 128'(err[0]),          128'(0));
    cyc(); smp(); chk("rd_idle_busy", 0, 128'(busy[0]), 128'(0));
    cyc();

    // Write to 0x200: AW ready at once, W ready only in cycle 4.
    aw0 = aw_cnt[0]; w0 = w_cnt[0];
    set_req(0, 1, 1, 32'h200, 32'hCAFEF00D); set_ready(0, 1, 0, 0);
    smp(); chk("wr_q_ready_c0", 0, 128'(trsp[0].q_ready), 128'(0));
    for (int c = 1; c < 4; c++) begin
      cyc(); smp();
      chk("wr_aw_dropped", 0, 128'(areq[0].aw_valid), 128'(0));
      chk("wr_q_ready_wait", 0, 128'(trsp[0].q_ready), 128'(0));
    end
    cyc(); set_ready(0, 1, 1, 0);
    smp(); chk("wr_q_ready_c4", 0, 128'(trsp[0].q_ready), 128'(1));
    cyc(); set_req(0, 0, 0, 32'h0, 32'h0); set_ready(0, 0, 0, 0);
    cyc(); set_b(0, 1, 2'b00);
    smp(); chk("wr_b_ready", 0, 128'(areq[0].b_ready), 128'(1));
    cyc(); set_b(0, 0, 2'b00);
    smp();
    chk("wr_p_valid", 0, 128'(trsp[0].p_valid), 128'(1));
    chk("wr_p_data",  0, 128'(trsp[0].p.data),  128'(0));
    chk("wr_aw_count", 0, 128'(aw_cnt[0] - aw0), 128'(1));
    chk("wr_w_count",  0, 128'(w_cnt[0] - w0),   128'(1));
    cyc(2);

    // Ordering: W, R, W issued; R offered before both Bs.
    set_ready(0, 1, 1, 1);
    set_req(0, 1, 1, 32'h300, 32'h11112222); cyc();
    set_req(0, 1, 0, 32'h304, 32'h0);        cyc();
    set_req(0, 1, 1, 32'h308, 32'h33334444); cyc();
    set_req(0, 0, 0, 32'h0, 32'h0);
    set_r(0, 1, 32'h5555AAAA, 2'b00);
    smp(); chk("ord_r_held_c3", 0, 128'(areq[0].r_ready), 128'(0));
    cyc(2); set_b(0, 1, 2'b00);
    smp(); chk("ord_r_held_c5", 0, 128'(areq[0].r_ready), 128'(0));
    cyc(); smp();
    chk("ord_p0_valid", 0, 128'(trsp[0].p_valid), 128'(1));
    chk("ord_p0_data",  0, 128'(trsp[0].p.data),  128'(0));
    chk("ord_b_wait",   0, 128'(areq[0].b_ready), 128'(0));
    cyc(); set_r(0, 0, 32'h0, 2'b00);
    smp();
    chk("ord_p1_data",  0, 128'(trsp[0].p.data),  128'(32'h5555AAAA));
    cyc(); set_b(0, 0, 2'b00);
    smp();
    chk("ord_p2_valid", 0, 128'(trsp[0].p_valid), 128'(1));
    chk("ord_p2_data",  0, 128'(trsp[0].p.data),  128'(0));
    idle(0);
    cyc(2);

    // Backpressure on the two-deep instance: three back-to-back reads.
    set_ready(1, 0, 0, 1);
    set_req(1, 1, 0, 32'h400, 32'h0); cyc();
    set_req(1, 1, 0, 32'h404, 32'h0); cyc();
    set_req(1, 1, 0, 32'h408, 32'h0);
    smp();
    chk("bp_q_ready_full", 1, 128'(trsp[1].q_ready),  128'(0));
    chk("bp_ar_valid_full", 1, 128'(areq[1].ar_valid), 128'(0));
    cyc(); set_r(1, 1, 32'h11, 2'b00);
    smp();
    chk("bp_q_ready_pop", 1, 128'(trsp[1].q_ready),  128'(0));
    chk("bp_ar_valid_pop", 1, 128'(areq[1].ar_valid), 128'(0));
    cyc(); set_r(1, 0, 32'h0, 2'b00);
    smp();
    chk("bp_q_ready_after", 1, 128'(trsp[1].q_ready), 128'(1));
    chk("bp_p_data0", 1, 128'(trsp[1].p.data), 128'(32'h11));
    cyc(); set_req(1, 0, 0, 32'h0, 32'h0); set_r(1, 1, 32'h22, 2'b00);
    cyc(); set_r(1, 1, 32'h33, 2'b00);
    smp(); chk("bp_p_data1", 1, 128'(trsp[1].p.data), 128'(32'h22));
    cyc(); set_r(1, 0, 32'h0, 2'b00);
    smp(); chk("bp_p_data2", 1, 128'(trsp[1].p.data), 128'(32'h33));
    idle(1);
    cyc(2);

    // Error response on a read: data forwarded, err pulses with p_valid.
    set_ready(0, 0, 0, 1);
    set_req(0, 1, 0, 32'h500, 32'h0); cyc();
    set_req(0, 0, 0, 32'h0, 32'h0);
    set_r(0, 1, 32'h1234, 2'b10);
    cyc(); set_r(0, 0, 32'h0, 2'b00);
    smp();
    chk("err_p_valid", 0, 128'(trsp[0].p_valid), 128'(1));
    chk("err_p_data",  0, 128'(trsp[0].p.data),  128'(32'h1234));
    chk("err_pulse",   0, 128'(err[0]),          128'(1));
    cyc(); smp(); chk("err_cleared", 0, 128'(err[0]), 128'(0));
    cyc();

    // Reset with two reads outstanding; a late R must not be consumed.
    set_req(0, 1, 0, 32'h600, 32'h0); cyc();
    set_req(0, 1, 0, 32'h604, 32'h0); cyc();
    set_req(0, 0, 0, 32'h0, 32'h0); set_ready(0, 0, 0, 0);
    rst = 1'b1;
    smp(); chk("mrst_busy_before", 0, 128'(busy[0]), 128'(1));
    cyc(); rst = 1'b0; set_r(0, 1, 32'h99, 2'b00);
    smp();
    chk("mrst_r_ready", 0, 128'(areq[0].r_ready), 128'(0));
    chk("mrst_busy",    0, 128'(busy[0]),         128'(0));
    chk("mrst_p_valid", 0, 128'(trsp[0].p_valid), 128'(0));
    chk("mrst_p_data",  0, 128'(trsp[0].p.data),  128'(0));
    cyc(); idle(0);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
